cdd_serial_link: RTL and testbench
==================================

# cdd_serial_link

Clocked-synchronous serial responder forming the drive-side end of the SH7034 SCI link in the CD subsystem. The SCI (master, clock-sync mode, internal SCK) drives SCK and TXD and samples RXD. This block samples command bits from SDI and returns status bits on SDO, one full frame per request. It buffers one status frame written by the drive model and one received command frame read back by it. It also generates and checks the frame checksums.

## Interface
- FRAME_LEN, 13: bytes per frame, both directions; valid range 2..16.
- TIMEOUT, 4096: CE ticks with no SCK edge mid-frame before the frame is aborted.

Ports (reset RST_N, asynchronous, active-low; clock CLK):
- CLK  in  1  system clock
- RST_N  in  1  async active-low reset
- CE  in  1  clock enable; all state advances only on CE
- SCK  in  1  serial clock from the SCI; idles high
- SDI  in  1  command data from SCI TXD
- SDO  out  1  status data to SCI RXD
- REQ_N  out  1  low = frame pending; routed to an SH-1 IRQ pin
- ST_WE  in  1  status buffer write strobe
- ST_ADDR  in  4  status buffer index
- ST_DATA  in  8  status byte
- ST_SEND  in  1  pulse: start frame
- BUSY  out  1  high in ARMED or XFER
- CMD_ADDR  in  4  command buffer read index
- CMD_DATA  out  8  combinational read of the command buffer
- CMD_RDY  out  1  one-CE pulse: full command frame received
- CMD_ERR  out  1  checksum result, valid with CMD_RDY and held until the next frame
- ABORT  out  1  one-CE pulse: timeout abort

## Operation
- **SCK edge detection:** SCK_OLD is registered on CE. rise = SCK & ~SCK_OLD; fall = ~SCK & SCK_OLD.
- **Bit order and edges:** LSB first, 8 bits per byte, no start or stop bits. On a fall, SDO drives the next status bit. On a rise, SDI shifts into the receive register MSB-side (the register shifts right).
- **IDLE:**
  - SDO=1, REQ_N=1.
  - ST_WE writes the status buffer.
  - ST_SEND moves the block to ARMED and clears CMD_ERR, the byte count, the bit count and both checksum accumulators.
- **ARMED:**
  - REQ_N=0.
  - The first fall loads the status shift register with byte 0, drives bit 0 onto SDO, and moves the block to XFER.
- **XFER, per fall:**
  - If bit count = 0, load the next status byte.
  - Drive the current bit onto SDO and shift.
  - REQ_N returns to 1 on the first fall.
- **XFER, per rise:**
  - Shift in SDI and increment the 3-bit bit count.
  - On the 8th rise, store the byte into the command buffer at the byte index, add it to the command sum, and increment the byte index.
- **Status checksum:**
  - Status byte FRAME_LEN-1 is never read from the buffer. It is transmitted as ~(sum of status bytes 0..FRAME_LEN-2) mod 256.
  - The status sum accumulates as each byte is loaded.
- **Command checksum:** CMD_ERR = (received byte FRAME_LEN-1 != ~(sum of bytes 0..FRAME_LEN-2) mod 256).
- **Frame completion:** after the 8th rise of byte FRAME_LEN-1, enter DONE for one CE, which pulses CMD_RDY, then return to IDLE.
- **Timeout:** in XFER, a 12-bit counter is cleared on every SCK edge and incremented each CE. Reaching TIMEOUT moves the block to IDLE with a one-CE ABORT pulse. The command buffer keeps its partial contents and CMD_RDY does not fire.
- **While BUSY:** ST_WE and ST_SEND are ignored.
- **Out-of-state edges:** SCK edges in IDLE or DONE are ignored.
- **Reset:**
  - All outputs take their reset values: SDO=1, REQ_N=1, BUSY=0, CMD_RDY=0, CMD_ERR=0, ABORT=0.
  - The state returns to IDLE and both buffers clear to 0x00.
  - A reset asserted mid-frame discards the frame.

## Timing
- The SCK-edge-to-action latency is exactly 1 CE, measured from the CE that samples the new SCK level.
- SDO changes no more than 2 CE after the SCK fall. The SCK half-period must be at least 4 CE, which guarantees SDO is stable before the SCI's sampling rise.
- CMD_RDY is asserted 1 CE after the final rise is processed.
- REQ_N is asserted on the CE after ST_SEND.
- ST_SEND coincident with ST_WE in IDLE: the write completes in the same CE and is included in the frame.

## Structure
- Package contents: state typedef (IDLE, ARMED, XFER, DONE) and the default FRAME_LEN and TIMEOUT constants, added to the CD subsystem package.
- One sub-module, cdd_frame_buf: 16×8 register array with a synchronous write port and an asynchronous read port. It is instantiated twice, once for the status buffer and once for the command buffer.

## Test plan
- **Good frame:** status bytes 0x00..0x0B written, ST_SEND, 13 bytes clocked with SDI = 12×0x00 then 0xFF. Required: REQ_N falls 1 CE after ST_SEND; SDO carries 0x00..0x0B then 0xBD, LSB first; CMD_RDY pulses once; CMD_ERR=0.
- **Bad checksum:** same frame with a last command byte of 0xFE. Required: CMD_ERR=1; CMD_DATA at address 12 reads 0xFE.
- **Timeout:** SCK stops after 5 bytes for 4096 CE. Required: one ABORT pulse, no CMD_RDY, BUSY=0, and a new ST_SEND is accepted.
- **Writes while busy:** ST_WE to address 0 with 0x55 during XFER. Required: the buffer is unchanged and the next frame sends the old byte 0.
- **Reset mid-frame:** RST_N asserted in byte 3. Required: SDO=1, REQ_N=1, BUSY=0, and CMD_DATA reads 0x00 at every address.
- **Minimum SCK timing:** SCK half-period of 4 CE. Required: a bit-exact loopback of 13 bytes.

Source files
------------

// File: rtl/cdd_serial_link_pkg.sv
// Shared types and defaults for the CD-drive SCI serial responder.
package cdd_serial_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_XFER,
    S_DONE
  } link_state_e;

  localparam int CDD_FRAME_LEN = 13;
  localparam int CDD_TIMEOUT   = 4096;
  localparam int CDD_TO_W      = 12;

  // Frame checksum byte: one's complement of the modulo-256 sum of the payload.
  function automatic logic [7:0] cdd_csum(input logic [7:0] sum);
    return ~sum;
  endfunction

endpackage

// File: rtl/cdd_frame_buf.sv
// 16x8 frame buffer: synchronous write, asynchronous read, cleared by reset.
module cdd_frame_buf (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [16];

  // NOTE: the array is built from flops, not a RAM macro, so it can and must be
  // cleared by reset; a RAM-inferred buffer could not take an async reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cdd_serial_link.sv
// Drive-side clocked-synchronous SCI responder: returns one status frame per
// request while capturing one command frame, with checksums both ways.
module cdd_serial_link
  import cdd_serial_link_pkg::*;
#(
  parameter int FRAME_LEN = CDD_FRAME_LEN,
  parameter int TIMEOUT   = CDD_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       SCK,
  input  logic       SDI,
  output logic       SDO,
  output logic       REQ_N,
  input  logic       ST_WE,
  input  logic [3:0] ST_ADDR,
  input  logic [7:0] ST_DATA,
  input  logic       ST_SEND,
  output logic       BUSY,
  input  logic [3:0] CMD_ADDR,
  output logic [7:0] CMD_DATA,
  output logic       CMD_RDY,
  output logic       CMD_ERR,
  output logic       ABORT
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  link_state_e         r_state, w_state_nxt;
  logic                r_sck_old, r_sdo, r_cmd_err, r_abort;
  logic [7:0]          r_tx_sh, r_rx_sh, r_st_sum, r_cmd_sum;
  logic [2:0]          r_bit_cnt;
  logic [4:0]          r_byte_idx;
  logic [CDD_TO_W-1:0] r_to_cnt;

  logic                w_rise, w_fall, w_edge, w_active, w_to_hit, w_load;
  logic                w_st_we, w_cmd_we;
  logic [CDD_TO_W:0]   w_to_next;
  logic [7:0]          w_st_rdata, w_tx_byte, w_rx_byte;

  assign w_rise    = SCK & ~r_sck_old;
  assign w_fall    = ~SCK & r_sck_old;
  assign w_edge    = w_rise | w_fall;
  assign w_active  = (r_state == S_ARMED) || (r_state == S_XFER);
  assign w_to_next = {1'b0, r_to_cnt} + {{CDD_TO_W{1'b0}}, 1'b1};
  assign w_to_hit  = !w_edge && (int'(w_to_next) >= TIMEOUT);

  // A new status byte is due on the arming fall and on every fall that opens a byte.
  assign w_load    = w_fall && ((r_state == S_ARMED) || (r_bit_cnt == 3'd0));
  assign w_tx_byte = (r_byte_idx == LAST_IDX) ? cdd_csum(r_st_sum) : w_st_rdata;
  assign w_rx_byte = {SDI, r_rx_sh[7:1]};

  assign w_st_we   = CE && ST_WE && (r_state == S_IDLE);
  assign w_cmd_we  = CE && (r_state == S_XFER) && w_rise && (r_bit_cnt == 3'd7);

  cdd_frame_buf u_status_buf (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (w_st_we),
    .i_waddr (ST_ADDR),
    .i_wdata (ST_DATA),
    .i_raddr (r_byte_idx[3:0]),
    .o_rdata (w_st_rdata)
  );

  cdd_frame_buf u_cmd_buf (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (w_cmd_we),
    .i_waddr (r_byte_idx[3:0]),
    .i_wdata (w_rx_byte),
    .i_raddr (CMD_ADDR),
    .o_rdata (CMD_DATA)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: combinational logic uses blocking assignments, and the default at the
  // top guarantees every path assigns w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (CE && ST_SEND) w_state_nxt = S_ARMED;
      S_ARMED: if (CE && w_fall)  w_state_nxt = S_XFER;
      S_XFER: begin
        if (CE) begin
          if (w_to_hit) begin
            w_state_nxt = S_IDLE;
          end else if (w_rise && (r_bit_cnt == 3'd7) && (r_byte_idx == LAST_IDX)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  if (CE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sck_old  <= 1'b1;
      r_sdo      <= 1'b1;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_st_sum   <= '0;
      r_cmd_sum  <= '0;
      r_cmd_err  <= 1'b0;
      r_abort    <= 1'b0;
      r_to_cnt   <= '0;
    end else if (CE) begin
      r_sck_old <= SCK;
      r_abort   <= (r_state == S_XFER) && w_to_hit;
      r_to_cnt  <= ((r_state == S_XFER) && !w_edge) ? w_to_next[CDD_TO_W-1:0] : '0;

      if ((r_state == S_IDLE) && ST_SEND) begin
        r_sdo      <= 1'b1;
        r_cmd_err  <= 1'b0;
        r_bit_cnt  <= '0;
        r_byte_idx <= '0;
        r_st_sum   <= '0;
        r_cmd_sum  <= '0;
      end

      if (w_active && w_fall) begin
        if (w_load) begin
          r_sdo    <= w_tx_byte[0];
          r_tx_sh  <= w_tx_byte >> 1;
          r_st_sum <= r_st_sum + w_tx_byte;
        end else begin
          r_sdo   <= r_tx_sh[0];
          r_tx_sh <= r_tx_sh >> 1;
        end
      end

      if ((r_state == S_XFER) && w_rise) begin
        r_rx_sh   <= w_rx_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_cmd_sum  <= r_cmd_sum + w_rx_byte;
          r_byte_idx <= r_byte_idx + 5'd1;
          if (r_byte_idx == LAST_IDX) r_cmd_err <= (w_rx_byte != cdd_csum(r_cmd_sum));
        end
      end
    end
  end

  assign SDO     = w_active ? r_sdo : 1'b1;
  assign REQ_N   = (r_state != S_ARMED);
  assign BUSY    = w_active;
  assign CMD_RDY = (r_state == S_DONE);
  assign CMD_ERR = r_cmd_err;
  assign ABORT   = r_abort;

endmodule

// File: tb/tb_cdd_serial_link.sv
// Directed bench for cdd_serial_link: plays the SCI master on a CE that runs at half the clock rate.
module tb_cdd_serial_link;

  logic       CLK = 1'b0;
  logic       CE  = 1'b0;
  logic       RST_N, SCK, SDI, SDO, REQ_N;
  logic       ST_WE, ST_SEND, BUSY, CMD_RDY, CMD_ERR, ABORT;
  logic [3:0] ST_ADDR, CMD_ADDR;
  logic [7:0] ST_DATA, CMD_DATA;

  int n_tests   = 0;
  int n_fail    = 0;
  int rdy_cnt   = 0;
  int abort_cnt = 0;

  logic [7:0] exp_st [13];
  logic [7:0] exp_cmd[13];
  logic [7:0] got_st [13];

  cdd_serial_link dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .SCK      (SCK),
    .SDI      (SDI),
    .SDO      (SDO),
    .REQ_N    (REQ_N),
    .ST_WE    (ST_WE),
    .ST_ADDR  (ST_ADDR),
    .ST_DATA  (ST_DATA),
    .ST_SEND  (ST_SEND),
    .BUSY     (BUSY),
    .CMD_ADDR (CMD_ADDR),
    .CMD_DATA (CMD_DATA),
    .CMD_RDY  (CMD_RDY),
    .CMD_ERR  (CMD_ERR),
    .ABORT    (ABORT)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) CE <= ~CE;

  always @(posedge CLK) begin
    if (CE && CMD_RDY) rdy_cnt   <= rdy_cnt + 1;
    if (CE && ABORT)   abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next CE-qualified rising edge.
  task automatic tick();
    @(posedge CLK);
    while (!CE) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic write_st(input logic [3:0] a, input logic [7:0] d);
    ST_WE = 1'b1; ST_ADDR = a; ST_DATA = d;
    tick();
    ST_WE = 1'b0;
  endtask

  task automatic send_byte(input int half, input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 0; i < 8; i++) begin
      SCK = 1'b0; SDI = tx[i];
      repeat (half) tick();
      rx[i] = SDO;
      SCK = 1'b1;
      repeat (half) tick();
    end
  endtask

  task automatic start_frame(input string tag, input logic with_we, input logic [7:0] d11);
    check({tag, "_req_n_idle"}, REQ_N, 1'b1);
    ST_SEND = 1'b1;
    if (with_we) begin
      ST_WE = 1'b1; ST_ADDR = 4'd11; ST_DATA = d11;
    end
    tick();
    ST_SEND = 1'b0; ST_WE = 1'b0;
    check({tag, "_req_n_armed"}, REQ_N, 1'b0);
    check({tag, "_busy_armed"}, BUSY, 1'b1);
  endtask

  task automatic run_bytes(input string tag, input int half, input int nbytes, input logic busy_write);
    logic [7:0] rx;
    for (int b = 0; b < nbytes; b++) begin
      send_byte(half, exp_cmd[b], rx);
      got_st[b] = rx;
      if (b == 0) begin
        check({tag, "_req_n_xfer"}, REQ_N, 1'b1);
        if (busy_write) begin
          ST_WE = 1'b1; ST_SEND = 1'b1; ST_ADDR = 4'd0; ST_DATA = 8'h55;
          tick();
          ST_WE = 1'b0; ST_SEND = 1'b0;
        end
      end
    end
  endtask

  task automatic full_frame(input string tag, input int half, input logic busy_write,
                            input logic with_we, input logic [7:0] d11);
    int r0;
    r0 = rdy_cnt;
    start_frame(tag, with_we, d11);
    run_bytes(tag, half, 13, busy_write);
    repeat (3) tick();
    for (int i = 0; i < 13; i++) check($sformatf("%s_sdo_b%0d", tag, i), got_st[i], exp_st[i]);
    check({tag, "_rdy_pulses"}, rdy_cnt - r0, 1);
    check({tag, "_busy_end"}, BUSY, 1'b0);
  endtask

  task automatic read_cmd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    CMD_ADDR = a;
    #1;
    check($sformatf("%s_cmd%0d", tag, a), CMD_DATA, exp);
  endtask

  initial begin
    int         a0, r0, n;
    logic [7:0] sum;

    RST_N = 1'b0; SCK = 1'b1; SDI = 1'b0;
    ST_WE = 1'b0; ST_SEND = 1'b0; ST_ADDR = '0; ST_DATA = '0; CMD_ADDR = '0;
    repeat (2) tick();
    check("rst_sdo", SDO, 1'b1);
    check("rst_req_n", REQ_N, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_cmd_rdy", CMD_RDY, 1'b0);
    check("rst_cmd_err", CMD_ERR, 1'b0);
    check("rst_abort", ABORT, 1'b0);
    read_cmd("rst", 4'd0, 8'h00);
    RST_N = 1'b1;
    repeat (2) tick();

    // Good frame: 0x00..0x0B sum to 0x42, checksum 0xBD; command checksum of zeros is 0xFF.
    for (int i = 0; i < 12; i++) begin
      write_st(4'(i), 8'(i));
      exp_st[i]  = 8'(i);
      exp_cmd[i] = 8'h00;
    end
    exp_st[12]  = 8'hBD;
    exp_cmd[12] = 8'hFF;
    full_frame("good", 6, 1'b0, 1'b0, 8'h00);
    check("good_cmd_err", CMD_ERR, 1'b0);

    exp_cmd[12] = 8'hFE;
    full_frame("bad", 6, 1'b0, 1'b0, 8'h00);
    check("bad_cmd_err", CMD_ERR, 1'b1);
    read_cmd("bad", 4'd12, 8'hFE);

    // Timeout: five bytes, then SCK parks high; the last edge is a rise.
    for (int i = 0; i < 5; i++) exp_cmd[i] = 8'hA0 + 8'(i);
    a0 = abort_cnt;
    r0 = rdy_cnt;
    start_frame("to", 1'b0, 8'h00);
    run_bytes("to", 6, 5, 1'b0);
    n = 0;
    while (!ABORT && n < 6000) begin
      tick();
      n++;
    end
    check("to_abort_latency", n, 4097 - 6);
    repeat (2) tick();
    check("to_abort_pulses", abort_cnt - a0, 1);
    check("to_no_rdy", rdy_cnt - r0, 0);
    check("to_busy", BUSY, 1'b0);
    check("to_cmd_err_cleared", CMD_ERR, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("to_sdo_b%0d", i), got_st[i], exp_st[i]);
    read_cmd("to", 4'd4, 8'hA4);

    // ST_WE/ST_SEND during XFER must be ignored; the following frame still sends 0x00 first.
    for (int i = 0; i < 12; i++) exp_cmd[i] = 8'h00;
    exp_cmd[12] = 8'hFF;
    full_frame("busy", 6, 1'b1, 1'b0, 8'h00);
    full_frame("after_busy", 6, 1'b0, 1'b0, 8'h00);
    check("after_busy_cmd_err", CMD_ERR, 1'b0);

    // Minimum SCK half-period, byte 11 written in the same CE as ST_SEND.
    sum = 8'h00;
    for (int i = 0; i < 12; i++) begin
      exp_st[i] = 8'(i * 37 + 5);
      sum       = sum + exp_st[i];
      if (i < 11) write_st(4'(i), exp_st[i]);
    end
    exp_st[12] = ~sum;
    sum = 8'h00;
    for (int i = 0; i < 12; i++) begin
      exp_cmd[i] = 8'hC3 ^ 8'(i * 11);
      sum        = sum + exp_cmd[i];
    end
    exp_cmd[12] = ~sum;
    full_frame("loop", 4, 1'b0, 1'b1, exp_st[11]);
    check("loop_cmd_err", CMD_ERR, 1'b0);
    for (int i = 0; i < 13; i++) read_cmd("loop", 4'(i), exp_cmd[i]);

    // Reset in the middle of byte 3.
    start_frame("mid", 1'b0, 8'h00);
    run_bytes("mid", 6, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b0; repeat (6) tick();
      SCK = 1'b1; repeat (6) tick();
    end
    SCK = 1'b0;
    repeat (2) tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_sdo", SDO, 1'b1);
    check("mid_rst_req_n", REQ_N, 1'b1);
    check("mid_rst_busy", BUSY, 1'b0);
    SCK = 1'b1;
    tick();
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) read_cmd("mid_rst", 4'(i), 8'h00);

    // Status buffer was cleared too: payload of zeros, checksum 0xFF.
    for (int i = 0; i < 12; i++) begin
      exp_st[i]  = 8'h00;
      exp_cmd[i] = 8'h00;
    end
    exp_st[12]  = 8'hFF;
    exp_cmd[12] = 8'hFF;
    full_frame("post_rst", 4, 1'b0, 1'b0, 8'h00);
    check("post_rst_cmd_err", CMD_ERR, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
